// File: rtl/qspi_rx_deser_if.sv
// Host-facing bundle of the QSPI receive deserializer: phase control, lane inputs
// and the byte stream handed to the host.
interface qspi_rx_deser_if #(
    parameter int LEN_W = 16
) ();
    logic             start;
    logic [LEN_W-1:0] len;
    logic [1:0]       mode;
    logic             abort;
    logic             sample_en;
    logic [3:0]       io_in;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, len, mode, abort, sample_en, io_in, rx_ready,
        input  rx_data, rx_valid, busy, done, overflow
    );

    modport slave (
        input  start, len, mode, abort, sample_en, io_in, rx_ready,
        output rx_data, rx_valid, busy, done, overflow
    );
endinterface

// File: rtl/qspi_rx_deser.sv
// QSPI read-data deserializer: shifts 1/2/4 lanes per sample strobe into MSB-first
// bytes and queues them in a small FIFO with a registered head for the host.
module qspi_rx_deser #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qspi_rx_deser_if.slave        bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [1:0]       mode_r;
    logic [7:0]       shift_r;
    logic [2:0]       samp_cnt_r;
    logic [LEN_W-1:0] bytes_left_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W:0]   rd_ptr_r;
    logic [PTR_W:0]   wr_ptr_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;

    logic [7:0]       shift_s;
    logic [2:0]       last_samp_s;
    logic             sample_s;
    logic             complete_s;
    logic             full_s;
    logic             rd_en_s;
    logic             wr_en_s;
    logic [PTR_W:0]   rd_ptr_nxt_s;
    logic [PTR_W:0]   wr_ptr_nxt_s;
    logic [7:0]       head_s;

    // Lane shifting, byte completion and FIFO pointer/head look-ahead
    always_comb begin
        shift_s     = {shift_r[6:0], bus.io_in[1]};
        last_samp_s = 3'd7;
        case (mode_r)
            2'b01: begin
                shift_s     = {shift_r[5:0], bus.io_in[1:0]};
                last_samp_s = 3'd3;
            end
            2'b10: begin
                shift_s     = {shift_r[3:0], bus.io_in};
                last_samp_s = 3'd1;
            end
            default: begin
                shift_s     = {shift_r[6:0], bus.io_in[1]};
                last_samp_s = 3'd7;
            end
        endcase
        sample_s   = (state_r == ST_RECV) && bus.sample_en && !bus.abort;
        complete_s = sample_s && (samp_cnt_r == last_samp_s);
        full_s     = (rd_ptr_r[PTR_W-1:0] == wr_ptr_r[PTR_W-1:0]) &&
                     (rd_ptr_r[PTR_W] != wr_ptr_r[PTR_W]);
        rd_en_s    = rx_valid_r && bus.rx_ready;
        // A read frees the slot on the same edge, so a full FIFO can still accept
        wr_en_s    = complete_s && (!full_s || rd_en_s);
        if (rd_en_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (wr_en_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (wr_en_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_s = shift_s;
        end else begin
            head_s = mem_r[rd_ptr_nxt_s[PTR_W-1:0]];
        end
    end

    // Phase FSM, shift register, FIFO storage and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mode_r       <= 2'b00;
            shift_r      <= 8'hFF;
            samp_cnt_r   <= 3'd0;
            bytes_left_r <= {LEN_W{1'b0}};
            rd_ptr_r     <= {(PTR_W+1){1'b0}};
            wr_ptr_r     <= {(PTR_W+1){1'b0}};
            rx_data_r    <= 8'hFF;
            rx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (bus.abort) begin
            state_r      <= ST_IDLE;
            shift_r      <= 8'hFF;
            samp_cnt_r   <= 3'd0;
            bytes_left_r <= {LEN_W{1'b0}};
            rd_ptr_r     <= {(PTR_W+1){1'b0}};
            wr_ptr_r     <= {(PTR_W+1){1'b0}};
            rx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= shift_s;
            end
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            rx_valid_r <= (rd_ptr_nxt_s != wr_ptr_nxt_s);
            if (rd_ptr_nxt_s != wr_ptr_nxt_s) begin
                rx_data_r <= head_s;
            end

            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mode_r     <= bus.mode;
                        overflow_r <= 1'b0;
                        samp_cnt_r <= 3'd0;
                        if (bus.len != {LEN_W{1'b0}}) begin
                            bytes_left_r <= bus.len;
                            state_r      <= ST_RECV;
                            busy_r       <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (sample_s) begin
                        shift_r <= shift_s;
                        if (complete_s) begin
                            samp_cnt_r   <= 3'd0;
                            bytes_left_r <= bytes_left_r - LEN_ONE;
                            if (full_s && !rd_en_s) begin
                                overflow_r <= 1'b1;
                            end
                            if (bytes_left_r == LEN_ONE) begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            samp_cnt_r <= samp_cnt_r + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_qspi_rx_deser.sv
// Directed bench for qspi_rx_deser: expected bytes are queued as lanes are driven
// and compared in order as the host side pops them.
module tb_qspi_rx_deser;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] bytes_s [6];

    qspi_rx_deser_if #(.LEN_W(16)) bus ();

    qspi_rx_deser #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_phase(input logic [15:0] l, input logic [1:0] m);
        bus.start = 1'b1;
        bus.len   = l;
        bus.mode  = m;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] io);
        bus.sample_en = 1'b1;
        bus.io_in     = io;
        tick();
        bus.sample_en = 1'b0;
        bus.io_in     = 4'h0;
    endtask

    // nsamp limits how many of the byte's samples are driven
    task automatic send_byte(input logic [7:0] b, input int lanes, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            if (lanes == 4)      strobe(b[7-4*i -: 4]);
            else if (lanes == 2) strobe({2'b00, b[7-2*i -: 2]});
            else                 strobe({2'b00, b[7-i], 1'b0});
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            guard++;
            chk({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
            if (bus.rx_valid !== 1'b1) begin
                exp_q.delete();
                break;
            end
            chk({tag, "_data"}, {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
            bus.rx_ready = 1'b1;
            tick();
            bus.rx_ready = 1'b0;
        end
        chk({tag, "_empty"}, {31'd0, bus.rx_valid}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = 16'd0; bus.mode = 2'b00; bus.abort = 1'b0;
        bus.sample_en = 1'b0; bus.io_in = 4'h0; bus.rx_ready = 1'b0;
        #12;
        chk("rst_data", {24'd0, bus.rx_data}, 32'hFF);
        chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // quad, two bytes
        start_phase(16'd2, 2'b10);
        chk("q_busy", {31'd0, bus.busy}, 32'd1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        strobe(4'hA);
        strobe(4'h5);
        chk("q_valid_lat", {31'd0, bus.rx_valid}, 32'd1);
        strobe(4'h3);
        strobe(4'hC);
        chk("q_done", {31'd0, bus.done}, 32'd1);
        chk("q_busy_done", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("q_done_1cyc", {31'd0, bus.done}, 32'd0);
        drain("q");

        // single lane, then mode 11 gives same byte; strobe in IDLE is ignored
        strobe(4'hF);
        chk("idle_strobe", {31'd0, bus.rx_valid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            start_phase(16'd1, (k == 0) ? 2'b00 : 2'b11);
            exp_q.push_back(8'hB2);
            send_byte(8'hB2, 1, 8);
            chk("s_done", {31'd0, bus.done}, 32'd1);
            tick();
            drain("s");
        end

        // dual, six bytes, host stalled: four held, overflow on fifth
        for (int i = 0; i < 6; i++) bytes_s[i] = 8'($urandom);
        start_phase(16'd6, 2'b01);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(bytes_s[i]);
            send_byte(bytes_s[i], 2, 4);
            if (i == 3) chk("d_no_ovf", {31'd0, bus.overflow}, 32'd0);
            if (i == 4) chk("d_ovf", {31'd0, bus.overflow}, 32'd1);
        end
        chk("d_done", {31'd0, bus.done}, 32'd1);
        tick();
        chk("d_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        drain("d");

        // full FIFO with a read on the edge the fifth byte completes
        for (int i = 0; i < 5; i++) bytes_s[i] = 8'($urandom);
        start_phase(16'd5, 2'b01);
        chk("f_ovf_clr", {31'd0, bus.overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bytes_s[i]);
            send_byte(bytes_s[i], 2, 4);
        end
        send_byte(bytes_s[4], 2, 3);
        chk("f_head", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        exp_q.push_back(bytes_s[4]);
        bus.rx_ready = 1'b1;
        strobe({2'b00, bytes_s[4][1:0]});
        bus.rx_ready = 1'b0;
        chk("f_no_ovf", {31'd0, bus.overflow}, 32'd0);
        chk("f_done", {31'd0, bus.done}, 32'd1);
        tick();
        drain("f");

        // abort after three quad samples, then a fresh phase
        start_phase(16'd3, 2'b10);
        send_byte(8'h12, 4, 2);
        strobe(4'h9);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        exp_q.delete();
        chk("a_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("a_busy", {31'd0, bus.busy}, 32'd0);
        chk("a_done", {31'd0, bus.done}, 32'd0);
        tick();
        chk("a_done2", {31'd0, bus.done}, 32'd0);
        start_phase(16'd1, 2'b10);
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, 4, 2);
        chk("a_next_done", {31'd0, bus.done}, 32'd1);
        tick();
        drain("a");

        // zero length
        start_phase(16'd0, 2'b10);
        chk("z_done", {31'd0, bus.done}, 32'd1);
        chk("z_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("z_done_off", {31'd0, bus.done}, 32'd0);
        chk("z_busy2", {31'd0, bus.busy}, 32'd0);

        // start during RECV is ignored: length and mode stay from first start
        start_phase(16'd1, 2'b10);
        start_phase(16'd5, 2'b00);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 4, 2);
        chk("r_done", {31'd0, bus.done}, 32'd1);
        tick();
        drain("r");

        // asynchronous reset mid-phase
        start_phase(16'd2, 2'b10);
        send_byte(8'h5A, 4, 2);
        chk("rm_valid_pre", {31'd0, bus.rx_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_data", {24'd0, bus.rx_data}, 32'hFF);
        chk("rm_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rm_busy", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
